// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the two requester ports (I fetch, D load/store), the shared memory
//   port and the busy flag of mem_port_arbiter.
//   Modports:
//     master : arbiter side (takes requests and memory responses, drives
//              grants, responses, memory strobes and busy)
//     slave  : environment side (requesters plus memory)
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // fetch requester
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_gnt;
   logic              i_valid;
   logic [DATA_W-1:0] i_rdata;
   logic              i_err;
   // data requester
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_valid;
   logic [DATA_W-1:0] d_rdata;
   logic              d_err;
   // memory port
   logic              m_re;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic              m_ack;
   logic [DATA_W-1:0] m_rdata;
   logic              m_err;
   // status
   logic              busy;

   modport master (
      input  i_req, i_addr,
      output i_gnt, i_valid, i_rdata, i_err,
      input  d_req, d_we, d_addr, d_wdata,
      output d_gnt, d_valid, d_rdata, d_err,
      output m_re, m_we, m_addr, m_wdata,
      input  m_ack, m_rdata, m_err,
      output busy
   );

   modport slave (
      output i_req, i_addr,
      input  i_gnt, i_valid, i_rdata, i_err,
      output d_req, d_we, d_addr, d_wdata,
      input  d_gnt, d_valid, d_rdata, d_err,
      input  m_re, m_we, m_addr, m_wdata,
      output m_ack, m_rdata, m_err,
      input  busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the fetch requester (I) and the
//   load/store requester (D). One transaction outstanding at a time:
//   IDLE latches the winning request, BUSY holds the memory strobe until
//   m_ack or timeout, RESP returns a one-cycle response to the owner.
//   Ports:
//     clk  : clock, rising edge
//     rst  : asynchronous active-high reset
//     bus  : mem_port_arbiter_if.master (requester, memory and busy signals)
//   Parameters: ADDR_W, DATA_W, D_PRIO (1: D wins ties, 0: round-robin),
//   TIMEOUT (BUSY cycles without m_ack before abort, >= 1).
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int D_PRIO  = 1,
   parameter int TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   mem_port_arbiter_if.master   bus
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              we_q;
   logic              owner_d_q;   // 1: D owns the transaction, 0: I
   logic              last_d_q;    // 1: D was granted last (round-robin)
   logic              err_q;
   logic [DATA_W-1:0] i_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;

   logic              pick_d;
   logic              take;
   logic              done;
   logic              tmo;
   logic              in_busy;
   logic              in_resp;

   // Winner selection; a lone requester always wins.
   always_comb begin
      pick_d = 1'b0;
      if (bus.d_req && !bus.i_req)
         pick_d = 1'b1;
      else if (bus.d_req && bus.i_req)
         pick_d = (D_PRIO != 0) ? 1'b1 : !last_d_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Next state; ack beats a timeout expiring in the same cycle.
   always_comb begin
      state_d = state_q;
      take    = 1'b0;
      done    = 1'b0;
      tmo     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.i_req || bus.d_req) begin
               take    = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (bus.m_ack) begin
               done    = 1'b1;
               state_d = RESP;
            end else if (cnt_q == TMO_LAST) begin
               tmo     = 1'b1;
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         owner_d_q <= 1'b0;
         last_d_q  <= 1'b0;
         err_q     <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         if (take) begin
            addr_q    <= pick_d ? bus.d_addr : bus.i_addr;
            wdata_q   <= pick_d ? bus.d_wdata : '0;
            we_q      <= pick_d & bus.d_we;
            owner_d_q <= pick_d;
            last_d_q  <= pick_d;
            cnt_q     <= '0;
            err_q     <= 1'b0;
         end
         if (state_q == BUSY && !done && !tmo)
            cnt_q <= cnt_q + 1'b1;
         if (done) begin
            err_q <= bus.m_err;
            if (!we_q) begin
               if (owner_d_q)
                  d_rdata_q <= bus.m_rdata;
               else
                  i_rdata_q <= bus.m_rdata;
            end
         end
         if (tmo)
            err_q <= 1'b1;
      end
   end

   // Outputs decode straight from state so reset drops strobes at once.
   // cnt_q is 0 only in the first BUSY cycle, which marks the grant pulse.
   assign in_busy = (state_q == BUSY);
   assign in_resp = (state_q == RESP);

   assign bus.m_re    = in_busy & ~we_q;
   assign bus.m_we    = in_busy &  we_q;
   assign bus.m_addr  = addr_q;
   assign bus.m_wdata = wdata_q;
   assign bus.busy    = in_busy | in_resp;

   assign bus.i_gnt   = in_busy & (cnt_q == '0) & ~owner_d_q;
   assign bus.d_gnt   = in_busy & (cnt_q == '0) &  owner_d_q;
   assign bus.i_valid = in_resp & ~owner_d_q;
   assign bus.d_valid = in_resp &  owner_d_q;
   assign bus.i_err   = in_resp & ~owner_d_q & err_q;
   assign bus.d_err   = in_resp &  owner_d_q & err_q;
   assign bus.i_rdata = i_rdata_q;
   assign bus.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   // ba: D-priority instance, bb: round-robin instance
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ba ();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bb ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .D_PRIO(1), .TIMEOUT(15)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ba)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .D_PRIO(0), .TIMEOUT(15)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bb)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      int         m_re_cycles;
      logic       seen_valid;
      logic       seen_err;
      int         ngr;
      logic [3:0] seq;
      int         ovl;

      ba.i_req = 0; ba.i_addr = '0; ba.d_req = 0; ba.d_we = 0; ba.d_addr = '0; ba.d_wdata = '0;
      ba.m_ack = 0; ba.m_rdata = '0; ba.m_err = 0;
      bb.i_req = 0; bb.i_addr = '0; bb.d_req = 0; bb.d_we = 0; bb.d_addr = '0; bb.d_wdata = '0;
      bb.m_ack = 0; bb.m_rdata = '0; bb.m_err = 0;

      // reset state
      tick(); tick();
      check("rst_busy",   ba.busy,    0);
      check("rst_m_re",   ba.m_re,    0);
      check("rst_m_addr", ba.m_addr,  0);
      check("rst_i_rdata",ba.i_rdata, 0);
      check("rst_gnt",    {ba.i_gnt, ba.d_gnt, ba.i_valid, ba.d_valid}, 0);
      rst = 0;

      // 1: I read 0x10, ack two cycles after gnt
      ba.i_req = 1; ba.i_addr = 32'h10;
      tick();
      check("t1_i_gnt",  ba.i_gnt, 1);
      check("t1_m_re_c1",ba.m_re,  1);
      check("t1_m_we",   ba.m_we,  0);
      check("t1_m_addr", ba.m_addr, 32'h10);
      ba.i_req = 0;
      tick();
      check("t1_gnt_pulse", ba.i_gnt, 0);
      check("t1_m_re_c2",   ba.m_re,  1);
      tick();
      check("t1_m_re_c3",   ba.m_re,  1);
      ba.m_ack = 1; ba.m_rdata = 32'h0000_0513;
      tick();
      ba.m_ack = 0;
      check("t1_i_valid", ba.i_valid, 1);
      check("t1_i_rdata", ba.i_rdata, 32'h0000_0513);
      check("t1_i_err",   ba.i_err,   0);
      check("t1_m_re_off",ba.m_re,    0);
      check("t1_busy_resp", ba.busy,  1);
      tick();
      check("t1_valid_pulse", ba.i_valid, 0);
      check("t1_idle_busy",   ba.busy,    0);

      // 2: simultaneous, D store wins, then I
      ba.i_req = 1; ba.i_addr = 32'h20;
      ba.d_req = 1; ba.d_we = 1; ba.d_addr = 32'h100; ba.d_wdata = 32'hDEAD_BEEF;
      tick();
      check("t2_d_gnt",   ba.d_gnt,  1);
      check("t2_i_gnt",   ba.i_gnt,  0);
      check("t2_m_we",    ba.m_we,   1);
      check("t2_m_re",    ba.m_re,   0);
      check("t2_m_wdata", ba.m_wdata, 32'hDEAD_BEEF);
      check("t2_m_addr",  ba.m_addr, 32'h100);
      ba.d_req = 0; ba.m_ack = 1; ba.m_rdata = 32'h9999_9999;
      tick();
      ba.m_ack = 0;
      check("t2_d_valid", ba.d_valid, 1);
      check("t2_i_valid", ba.i_valid, 0);
      check("t2_d_err",   ba.d_err,   0);
      check("t2_d_rdata_keep", ba.d_rdata, 0);
      tick();
      check("t2_idle_no_gnt", ba.i_gnt, 0);
      tick();
      check("t2_i_gnt_after", ba.i_gnt, 1);
      check("t2_i_addr",      ba.m_addr, 32'h20);
      check("t2_i_m_re",      ba.m_re,   1);
      ba.i_req = 0; ba.m_ack = 1; ba.m_rdata = 32'h1111_2222;
      tick();
      ba.m_ack = 0;
      check("t2_i_valid", ba.i_valid, 1);
      check("t2_i_rdata", ba.i_rdata, 32'h1111_2222);
      tick();

      // 5a: ack in IDLE ignored
      ba.m_ack = 1; ba.m_err = 1; ba.m_rdata = 32'h5555_5555;
      tick();
      check("t5_idle_valid", {ba.i_valid, ba.d_valid}, 0);
      tick();
      check("t5_idle_valid2", {ba.i_valid, ba.d_valid}, 0);
      check("t5_idle_busy",   ba.busy, 0);
      check("t5_idle_rdata",  ba.i_rdata, 32'h1111_2222);
      ba.m_ack = 0; ba.m_err = 0;
      // 5b: bus error on I read
      ba.i_req = 1; ba.i_addr = 32'h30;
      tick();
      ba.i_req = 0; ba.m_ack = 1; ba.m_err = 1; ba.m_rdata = 32'h0000_0BAD;
      tick();
      ba.m_ack = 0; ba.m_err = 0;
      check("t5_i_valid", ba.i_valid, 1);
      check("t5_i_err",   ba.i_err,   1);
      check("t5_d_err",   ba.d_err,   0);
      check("t5_i_rdata", ba.i_rdata, 32'h0000_0BAD);
      tick();

      // 4a: D load times out
      ba.d_req = 1; ba.d_we = 0; ba.d_addr = 32'h40;
      tick();
      check("t4_d_gnt", ba.d_gnt, 1);
      ba.d_req = 0;
      m_re_cycles = ba.m_re ? 1 : 0;
      seen_valid = 0; seen_err = 0;
      for (int c = 0; c < 30; c++) begin
         tick();
         if (ba.m_re) m_re_cycles++;
         if (ba.d_valid) begin
            seen_valid = 1; seen_err = ba.d_err;
            break;
         end
      end
      check("t4_m_re_cycles", m_re_cycles, 15);
      check("t4_d_valid",     seen_valid, 1);
      check("t4_d_err",       seen_err,   1);
      check("t4_d_rdata",     ba.d_rdata, 0);
      tick();
      check("t4_back_idle",   ba.busy, 0);

      // 4b: ack in the last BUSY cycle wins over timeout
      ba.d_req = 1; ba.d_we = 0; ba.d_addr = 32'h44;
      tick();
      ba.d_req = 0;
      repeat (14) tick();
      check("t4b_m_re_c15", ba.m_re, 1);
      ba.m_ack = 1; ba.m_err = 0; ba.m_rdata = 32'h0000_ABCD;
      tick();
      ba.m_ack = 0;
      check("t4b_d_valid", ba.d_valid, 1);
      check("t4b_d_err",   ba.d_err,   0);
      check("t4b_d_rdata", ba.d_rdata, 32'h0000_ABCD);
      tick();

      // 6: reset mid-BUSY
      ba.i_req = 1; ba.i_addr = 32'h50;
      tick();
      ba.i_req = 0;
      tick();
      #2 rst = 1;
      #1;
      check("t6_m_re_rst", ba.m_re, 0);
      check("t6_busy_rst", ba.busy, 0);
      check("t6_m_we_rst", ba.m_we, 0);
      tick();
      check("t6_no_valid", {ba.i_valid, ba.d_valid}, 0);
      check("t6_rdata_rst", ba.i_rdata, 0);
      ba.i_req = 1; ba.i_addr = 32'h60;
      rst = 0;
      tick();
      check("t6_i_gnt",  ba.i_gnt,  1);
      check("t6_m_addr", ba.m_addr, 32'h60);
      ba.i_req = 0; ba.m_ack = 1; ba.m_rdata = 32'h77;
      tick();
      ba.m_ack = 0;
      check("t6_i_valid", ba.i_valid, 1);
      check("t6_i_rdata", ba.i_rdata, 32'h77);
      tick();

      // 3: round-robin, both held, memory always acking
      bb.i_req = 1; bb.i_addr = 32'h80;
      bb.d_req = 1; bb.d_we = 0; bb.d_addr = 32'h90;
      bb.m_ack = 1; bb.m_rdata = 32'h3;
      ngr = 0; seq = '0; ovl = 0;
      for (int c = 0; c < 30 && ngr < 4; c++) begin
         tick();
         if ((bb.i_gnt && bb.d_gnt) || (bb.i_valid && bb.d_valid)) ovl++;
         if (bb.d_gnt) begin
            seq[ngr] = 1'b1; ngr++;
         end else if (bb.i_gnt) begin
            seq[ngr] = 1'b0; ngr++;
         end
      end
      bb.i_req = 0; bb.d_req = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if ((bb.i_gnt && bb.d_gnt) || (bb.i_valid && bb.d_valid)) ovl++;
      end
      bb.m_ack = 0;
      check("t3_grants", ngr, 4);
      check("t3_order_DIDI", seq, 4'b0101);
      check("t3_no_overlap", ovl, 0);
      tick();
      check("t3_idle", bb.busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
